// File: rtl/conv_pkg.sv
// Shared constants, enable encodings, FSM state type and saturation helper
// for the serial 3x3 convolution engine.
// Pure declarations; no timing or flow-control behaviour of its own.
package conv_pkg;

  localparam int ELEM_W = 8;
  localparam int SUM_W  = 20;
  localparam int ADDR_W = 6;

  localparam int IN_DIM  = 4;
  localparam int FLT_DIM = 3;
  localparam int OUT_DIM = 2;
  localparam int FLT_N   = FLT_DIM * FLT_DIM;
  localparam int OUT_N   = OUT_DIM * OUT_DIM;

  localparam int IN_BASE_DEF  = 0;
  localparam int FLT_BASE_DEF = 16;
  localparam int OUT_BASE_DEF = 25;

  // {ce,we} pairs presented to each memory region
  localparam logic [1:0] EN_OFF = 2'b00;
  localparam logic [1:0] EN_RD  = 2'b10;
  localparam logic [1:0] EN_WR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LD_F,
    LD_WAIT,
    MAC,
    MAC_WAIT,
    WR,
    DONE
  } state_t;

  // Clamp an accumulator value to the unsigned 8-bit range
  function automatic logic [ELEM_W-1:0] sat8(input logic [SUM_W-1:0] v);
    return (|v[SUM_W-1:ELEM_W]) ? {ELEM_W{1'b1}} : v[ELEM_W-1:0];
  endfunction

endpackage

// File: rtl/conv_serial_engine_if.sv
// Memory-side bus of the convolution engine: shared address/data plus
// per-region {ce,we} enables and the two read-data returns.
// Read data is valid one cycle after its address; there is no stall path.
interface conv_serial_engine_if;
  import conv_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_data;
  logic [1:0]        en_INPUT;
  logic [1:0]        en_FILTER;
  logic [1:0]        en_OUT1;
  logic [ELEM_W-1:0] out_A;
  logic [ELEM_W-1:0] out_F;

  modport master (
    output mem_addr, mem_data, en_INPUT, en_FILTER, en_OUT1,
    input  out_A, out_F
  );

  modport slave (
    input  mem_addr, mem_data, en_INPUT, en_FILTER, en_OUT1,
    output out_A, out_F
  );

endinterface

// File: rtl/mac_unit.sv
// Single multiply-accumulate lane: 8x8 unsigned product into a 20-bit sum.
// Accumulates on the edge after en; sat result is combinational from acc.
// No backpressure: clr has priority over en and takes one edge.
module mac_unit
  import conv_pkg::*;
#(
  parameter int DATA_W = ELEM_W,
  parameter int ACC_W  = SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ELEM_W-1:0] res
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc;

  assign prod = a * b;
  assign res  = sat8(acc);

  // Accumulator: synchronous clear wins over accumulate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_serial_engine.sv
// Serial 3x3 valid convolution of a 4x4 matrix, one MAC per cycle, results to OUT1.
// 55 cycles from start to done: 9 filter reads, then 11 cycles per output.
// No backpressure: memory reads are fixed one-cycle latency, writes take one cycle.
module conv_serial_engine
  import conv_pkg::*;
#(
  parameter int DATA_W   = ELEM_W,
  parameter int ACC_W    = SUM_W,
  parameter int IN_BASE  = IN_BASE_DEF,
  parameter int FLT_BASE = FLT_BASE_DEF,
  parameter int OUT_BASE = OUT_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  conv_serial_engine_if.master bus
);

  localparam logic [3:0] K_LAST   = 4'(FLT_N - 1);
  localparam logic [1:0] KC_LAST  = 2'(FLT_DIM - 1);
  localparam logic [1:0] IDX_LAST = 2'(OUT_N - 1);

  state_t            state, nxt;
  logic [3:0]        k, k_prev;
  logic [1:0]        kr, kc, idx;
  logic              f_vld, a_vld;
  logic [DATA_W-1:0] f [FLT_N];
  logic              mac_clr;
  logic [ELEM_W-1:0] res;
  logic [2:0]        row, col;
  logic [ADDR_W-1:0] a_addr, f_addr, o_addr;

  assign row    = 3'(kr) + 3'(idx[1]);
  assign col    = 3'(kc) + 3'(idx[0]);
  assign a_addr = ADDR_W'(IN_BASE) + ADDR_W'(row) * ADDR_W'(IN_DIM) + ADDR_W'(col);
  assign f_addr = ADDR_W'(FLT_BASE) + ADDR_W'(k);
  assign o_addr = ADDR_W'(OUT_BASE) + ADDR_W'(idx);

  // The sum is restarted before the first output and between outputs
  assign mac_clr = (state == LD_WAIT) || (state == WR && idx != IDX_LAST);

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (a_vld),
    .a   (bus.out_A),
    .b   (f[k_prev]),
    .res (res)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next state and all bus outputs decoded from the current state
  always_comb begin
    nxt           = state;
    busy          = 1'b0;
    done          = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.en_INPUT  = EN_OFF;
    bus.en_FILTER = EN_OFF;
    bus.en_OUT1   = EN_OFF;
    case (state)
      IDLE: begin
        if (start) nxt = LD_F;
      end
      LD_F: begin
        busy          = 1'b1;
        bus.mem_addr  = f_addr;
        bus.en_FILTER = EN_RD;
        if (k == K_LAST) nxt = LD_WAIT;
      end
      LD_WAIT: begin
        busy = 1'b1;
        nxt  = MAC;
      end
      MAC: begin
        busy         = 1'b1;
        bus.mem_addr = a_addr;
        bus.en_INPUT = EN_RD;
        if (k == K_LAST) nxt = MAC_WAIT;
      end
      MAC_WAIT: begin
        busy = 1'b1;
        nxt  = WR;
      end
      WR: begin
        busy         = 1'b1;
        bus.mem_addr = o_addr;
        bus.mem_data = res;
        bus.en_OUT1  = EN_WR;
        nxt          = (idx == IDX_LAST) ? DONE : MAC;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Element counters: k walks the 9 taps, kr/kc track it row-major, idx the output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k   <= '0;
      kr  <= '0;
      kc  <= '0;
      idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k   <= '0;
            kr  <= '0;
            kc  <= '0;
            idx <= '0;
          end
        end
        LD_F: k <= (k == K_LAST) ? '0 : k + 4'd1;
        MAC: begin
          k <= (k == K_LAST) ? '0 : k + 4'd1;
          if (kc == KC_LAST) begin
            kc <= '0;
            kr <= (kr == KC_LAST) ? '0 : kr + 2'd1;
          end else begin
            kc <= kc + 2'd1;
          end
        end
        WR: if (idx != IDX_LAST) idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end

  // Remember which tap each outstanding read belongs to, for the returning data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_vld  <= 1'b0;
      a_vld  <= 1'b0;
      k_prev <= '0;
    end else begin
      f_vld  <= (state == LD_F);
      a_vld  <= (state == MAC);
      k_prev <= k;
    end
  end

  // Filter register file, refilled from out_F on every run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLT_N; i++) f[i] <= '0;
    end else if (f_vld) begin
      f[k_prev] <= bus.out_F;
    end
  end

endmodule

// File: tb/tb_conv_serial_engine.sv
// Directed bench for conv_serial_engine with a small region-mapped memory model.
// Checks reset state, results for several matrices, cycle timing and enables.
// Memory model answers reads one cycle after the address, never stalls.
module tb_conv_serial_engine;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  conv_serial_engine_if bus();

  conv_serial_engine dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] img [16];
  logic [7:0] flt [9];
  logic [7:0] out_mem [4];
  int         wr_cnt;
  int         stray_wr;
  logic       clr_out;

  // Memory model: registered reads per region, OUT1 writes logged per address
  always @(posedge clk) begin
    if (bus.en_INPUT == EN_RD)
      bus.out_A <= (int'(bus.mem_addr) < 16) ? img[int'(bus.mem_addr)] : 8'h00;
    if (bus.en_FILTER == EN_RD)
      bus.out_F <= (int'(bus.mem_addr) >= 16 && int'(bus.mem_addr) < 25) ?
                   flt[int'(bus.mem_addr) - 16] : 8'h00;
    if (clr_out) begin
      for (int i = 0; i < 4; i++) out_mem[i] <= 8'hEE;
      wr_cnt   <= 0;
      stray_wr <= 0;
    end else if (bus.en_OUT1 == EN_WR) begin
      wr_cnt <= wr_cnt + 1;
      if (int'(bus.mem_addr) >= 25 && int'(bus.mem_addr) < 29)
        out_mem[int'(bus.mem_addr) - 25] <= bus.mem_data;
      else
        stray_wr <= stray_wr + 1;
    end
  end

  logic       busy_tr [128];
  logic       done_tr [128];
  logic [5:0] addr_tr [128];
  logic [7:0] data_tr [128];
  logic [1:0] ei_tr [128];
  logic [1:0] ef_tr [128];
  logic [1:0] eo_tr [128];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_out();
    clr_out = 1'b1;
    @(posedge clk);
    #1;
    clr_out = 1'b0;
  endtask

  // Launch with start sampled at edge 0, then trace cycles 1..ncyc
  task automatic run(input int ncyc, input int pulse_at, input int hold_until);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= ncyc; c++) begin
      busy_tr[c] = busy;
      done_tr[c] = done;
      addr_tr[c] = bus.mem_addr;
      data_tr[c] = bus.mem_data;
      ei_tr[c]   = bus.en_INPUT;
      ef_tr[c]   = bus.en_FILTER;
      eo_tr[c]   = bus.en_OUT1;
      start      = (c <= hold_until) || (c == pulse_at);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic chk_outputs(input string tag, input int y0, input int y1,
                             input int y2, input int y3);
    chk({tag, "_y0"}, int'(out_mem[0]), y0);
    chk({tag, "_y1"}, int'(out_mem[1]), y1);
    chk({tag, "_y2"}, int'(out_mem[2]), y2);
    chk({tag, "_y3"}, int'(out_mem[3]), y3);
    chk({tag, "_wr_cnt"}, wr_cnt, 4);
    chk({tag, "_stray"}, stray_wr, 0);
  endtask

  initial begin
    int bad;
    int cnt;
    int last;
    int rd0 [9];
    rd0 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    // Reset state, checked before any clock edge
    rst     = 1'b0;
    start   = 1'b0;
    clr_out = 1'b0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_en_data", int'({bus.en_INPUT, bus.en_FILTER, bus.en_OUT1, bus.mem_data}), 0);
    #20;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // All ones: every window sums to 9; full cycle trace on this run
    for (int i = 0; i < 16; i++) img[i] = 8'd1;
    for (int i = 0; i < 9; i++)  flt[i] = 8'd1;
    clear_out();
    run(60, 0, 0);
    chk_outputs("ones", 9, 9, 9, 9);

    bad = 0;
    for (int c = 1; c <= 60; c++)
      if (busy_tr[c] !== ((c >= 1) && (c <= 54))) bad++;
    chk("busy_window", bad, 0);
    cnt = 0;
    last = 0;
    for (int c = 1; c <= 60; c++)
      if (done_tr[c]) begin cnt++; last = c; end
    chk("done_count", cnt, 1);
    chk("done_cycle", last, 55);
    for (int k = 0; k < 9; k++)
      chk("flt_read", int'(ef_tr[1 + k]) * 64 + int'(addr_tr[1 + k]), 2 * 64 + 16 + k);
    for (int i = 0; i < 9; i++)
      chk("out0_read", int'(ei_tr[11 + i]) * 64 + int'(addr_tr[11 + i]), 2 * 64 + rd0[i]);
    for (int n = 0; n < 4; n++)
      chk("wr_cycle", int'(eo_tr[21 + 11 * n]) * 16384 + int'(addr_tr[21 + 11 * n]) * 256
          + int'(data_tr[21 + 11 * n]), 3 * 16384 + (25 + n) * 256 + 9);
    cnt = 0;
    bad = 0;
    for (int c = 1; c <= 60; c++) begin
      if (eo_tr[c] == EN_WR) cnt++;
      if ((int'(ei_tr[c] != 0) + int'(ef_tr[c] != 0) + int'(eo_tr[c] != 0)) > 1) bad++;
    end
    chk("wr_en_cycles", cnt, 4);
    chk("en_overlap", bad, 0);

    // Ramp input, centre tap only: outputs are the inner 2x2 of the ramp
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    for (int i = 0; i < 9; i++)  flt[i] = 8'd0;
    flt[4] = 8'd1;
    clear_out();
    run(60, 0, 0);
    chk_outputs("centre", 5, 6, 9, 10);

    // Asymmetric taps F[0][2]=2, F[2][0]=1: y = 2*A[r][c+2] + A[r+2][c]
    for (int i = 0; i < 9; i++) flt[i] = 8'd0;
    flt[2] = 8'd2;
    flt[6] = 8'd1;
    clear_out();
    run(60, 0, 0);
    chk_outputs("asym", 12, 15, 24, 27);

    // All 255: 585225 saturates
    for (int i = 0; i < 16; i++) img[i] = 8'd255;
    for (int i = 0; i < 9; i++)  flt[i] = 8'd255;
    clear_out();
    run(60, 0, 0);
    chk_outputs("sat", 255, 255, 255, 255);

    // Reset during output 1 MAC (cycle 30): only address 25 was written
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    for (int i = 0; i < 9; i++)  flt[i] = 8'd0;
    flt[4] = 8'd1;
    clear_out();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 30; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_addr", int'(bus.mem_addr), 0);
    chk("midrst_en_data", int'({bus.en_INPUT, bus.en_FILTER, bus.en_OUT1, bus.mem_data}), 0);
    @(posedge clk);
    #1;
    chk("midrst_y0", int'(out_mem[0]), 5);
    chk("midrst_y1", int'(out_mem[1]), 8'hEE);
    chk("midrst_y3", int'(out_mem[3]), 8'hEE);
    chk("midrst_wr_cnt", wr_cnt, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_out();
    run(60, 0, 0);
    chk_outputs("after_rst", 5, 6, 9, 10);

    // Start pulsed mid-run is ignored
    clear_out();
    run(60, 20, 0);
    cnt = 0;
    last = 0;
    for (int c = 1; c <= 60; c++)
      if (done_tr[c]) begin cnt++; last = c; end
    chk("ign_done_count", cnt, 1);
    chk("ign_done_cycle", last, 55);
    chk("ign_wr_cnt", wr_cnt, 4);

    // Start held through the first done: second run's busy begins at cycle 57
    clear_out();
    run(115, 0, 57);
    cnt = 0;
    for (int c = 1; c <= 115; c++)
      if (done_tr[c]) cnt++;
    chk("b2b_done_count", cnt, 2);
    chk("b2b_busy56", int'(busy_tr[56]), 0);
    chk("b2b_busy57", int'(busy_tr[57]), 1);
    chk("b2b_done111", int'(done_tr[111]), 1);
    chk("b2b_wr_cnt", wr_cnt, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
